sd_cmd_generator: RTL and testbench
===================================

Name: sd_cmd_generator

Overview:
- Builds and issues one 6-byte SD-card SPI-mode command frame through a byte-wide SPI master (CPOL0/CPHA0).
- Frame is start/transmission bits, 6-bit command index, 32-bit argument, then CRC7 with end bit.
- Polls for the R1 response byte, then returns the response with done/ready strobes.
- Sits between the SD-card controller FSM and the SPI master, and owns the card chip-select.

Parameters:
- NCR_MAX, default 8: maximum 0xFF poll bytes sent while waiting for R1 before timeout.
- FILL_BYTE, default 8'hFF: byte transmitted during polling and trailer.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- cmd  input  6  command index; sampled when go is accepted.
- arg  input  32  command argument; sampled when go is accepted.
- go  input  1  start request; honoured only in IDLE.
- ignore_count  input  1  1 = wait for R1 indefinitely (NCR_MAX ignored); sampled with go.
- done  output  1  one-cycle pulse at end of transaction.
- response  output  8  R1 byte, or 8'hFF on timeout; held until next accepted go.
- response_ready  output  1  one-cycle pulse when response is updated.
- data_xfer_in_progress  output  1  high from go acceptance until done pulse (busy).
- spi_go  output  1  one-cycle strobe to SPI master to shift spi_tx_data.
- spi_tx_data  output  8  byte to transmit; stable from spi_go until spi_done.
- spi_rx_data  input  8  byte received; valid in the cycle spi_done is high.
- spi_done  input  1  one-cycle pulse from SPI master: byte exchange complete.
- spi_cs  output  1  card chip-select, active-low.

Behaviour:
- Reset (rst=0, async): state IDLE; done=0, response=8'hFF, response_ready=0, data_xfer_in_progress=0, spi_go=0, spi_tx_data=8'hFF, spi_cs=1. Reset mid-transaction aborts immediately with CS released; no done pulse.
- IDLE: on go=1, latch cmd, arg, ignore_count.
  - Build frame byte0 = {2'b01, cmd}, bytes1-4 = arg MSB first, byte5 = {crc7, 1'b1}.
  - crc7 uses polynomial x^7+x^3+1, init 0, over the 40 bits of bytes0-4, MSB first.
  - Assert data_xfer_in_progress; go to SEND.
- SEND: drive spi_cs=0 and spi_tx_data = current frame byte; pulse spi_go for 1 cycle. Go to WAIT.
- WAIT: hold outputs until spi_done. Then advance the byte index.
  - After byte5 go to POLL (reset poll counter); otherwise go back to SEND.
- POLL: send FILL_BYTE via the same spi_go/spi_done handshake. On spi_done:
  - If spi_rx_data[7]==0: latch response=spi_rx_data, go to TRAIL.
  - Else increment poll counter. If counter==NCR_MAX and ignore_count==0: response=8'hFF, go to TRAIL. Else poll again.
- TRAIL: set spi_cs=1, send one FILL_BYTE (8 clocks for card release). On spi_done go to FIN.
- FIN: pulse done and response_ready together for 1 cycle; clear data_xfer_in_progress in the same cycle; return to IDLE.
- go while not IDLE is ignored. spi_done outside WAIT/POLL/TRAIL is ignored.
- spi_go is never asserted while a previous byte is outstanding. Exactly one spi_go per byte.
- Total bytes per transaction: 6 + polls (1..NCR_MAX, or unbounded) + 1 trailer.
- response is never modified except at FIN and reset.

Test Plan:
- Reset, then cmd=0, arg=0, go. SPI model returns 0xFF, 0xFF, 0x01 on poll bytes -> tx bytes 40 00 00 00 00 95, three FF poll bytes, one FF trailer with cs=1. done and response_ready pulse once; response=0x01.
- cmd=8, arg=0x000001AA, card answers 0x01 on first poll -> tx 48 00 00 01 AA 87; response=0x01.
- cmd=0x3F, arg=0, card never answers, ignore_count=0 -> exactly 8 poll bytes. Then response=0xFF, done pulses, spi_cs returns 1.
- Same as above but ignore_count=1; card answers 0x00 after 20 polls -> 20 poll bytes, response=0x00.
- go pulsed again mid-transaction -> no effect; frame and byte count unchanged. data_xfer_in_progress stays high until done.
- Assert rst low during the argument bytes -> spi_cs=1, spi_go=0, response=0xFF immediately; no done. Next go runs a full transaction.

Source files
------------

// File: rtl/sd_cmd_generator.sv
// SD-card SPI-mode command issuer: frames cmd/arg with CRC7, drives the byte-wide
// SPI master, polls for the R1 byte and hands it back with done/ready strobes.
module sd_cmd_generator #(
  parameter int          NCR_MAX   = 8,
  parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  cmd,
  input  logic [31:0] arg,
  input  logic        go,
  input  logic        ignore_count,
  output logic        done,
  output logic [7:0]  response,
  output logic        response_ready,
  output logic        data_xfer_in_progress,
  output logic        spi_go,
  output logic [7:0]  spi_tx_data,
  input  logic [7:0]  spi_rx_data,
  input  logic        spi_done,
  output logic        spi_cs
);

  localparam int CW = $clog2(NCR_MAX + 1);
  localparam logic [CW-1:0] NCR_LIM = CW'(NCR_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT, S_POLL, S_PWAIT, S_TRAIL, S_TWAIT, S_FIN
  } state_e;

  state_e          state_q;
  logic [47:0]     frame_q;
  logic [2:0]      idx_q;
  logic [CW-1:0]   poll_cnt_q;
  logic            ign_q;
  logic [7:0]      resp_buf_q;
  logic            done_q, rdy_q, busy_q, spi_go_q, spi_cs_q;
  logic [7:0]      response_q, spi_tx_q;
  logic [39:0]     hdr_d;

  // CRC7 (x^7 + x^3 + 1), MSB-first over the 40 header bits
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign hdr_d = {2'b01, cmd, arg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      idx_q      <= '0;
      poll_cnt_q <= '0;
      ign_q      <= 1'b0;
      resp_buf_q <= 8'hFF;
      done_q     <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      spi_go_q   <= 1'b0;
      spi_cs_q   <= 1'b1;
      response_q <= 8'hFF;
      spi_tx_q   <= 8'hFF;
    end else begin
      done_q   <= 1'b0;
      rdy_q    <= 1'b0;
      spi_go_q <= 1'b0;
      case (state_q)
        S_IDLE: if (go) begin
          frame_q <= {hdr_d, crc7(hdr_d), 1'b1};
          ign_q   <= ignore_count;
          idx_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= S_SEND;
        end
        S_SEND: begin
          spi_cs_q <= 1'b0;
          spi_tx_q <= frame_q[47:40];
          spi_go_q <= 1'b1;
          state_q  <= S_WAIT;
        end
        S_WAIT: if (spi_done) begin
          frame_q <= frame_q << 8;
          if (idx_q == 3'd5) begin
            poll_cnt_q <= '0;
            state_q    <= S_POLL;
          end else begin
            idx_q   <= idx_q + 3'd1;
            state_q <= S_SEND;
          end
        end
        S_POLL: begin
          spi_tx_q <= FILL_BYTE;
          spi_go_q <= 1'b1;
          state_q  <= S_PWAIT;
        end
        S_PWAIT: if (spi_done) begin
          if (!spi_rx_data[7]) begin
            resp_buf_q <= spi_rx_data;
            state_q    <= S_TRAIL;
          end else begin
            poll_cnt_q <= poll_cnt_q + 1'b1;
            if (!ign_q && (poll_cnt_q + 1'b1) == NCR_LIM) begin
              resp_buf_q <= 8'hFF;
              state_q    <= S_TRAIL;
            end else begin
              state_q <= S_POLL;
            end
          end
        end
        // CS released before the trailer so the card gets 8 clocks to let go of MISO
        S_TRAIL: begin
          spi_cs_q <= 1'b1;
          spi_tx_q <= FILL_BYTE;
          spi_go_q <= 1'b1;
          state_q  <= S_TWAIT;
        end
        S_TWAIT: if (spi_done) begin
          done_q     <= 1'b1;
          rdy_q      <= 1'b1;
          response_q <= resp_buf_q;
          busy_q     <= 1'b0;
          state_q    <= S_FIN;
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done                  = done_q;
  assign response_ready        = rdy_q;
  assign response              = response_q;
  assign data_xfer_in_progress = busy_q;
  assign spi_go                = spi_go_q;
  assign spi_tx_data           = spi_tx_q;
  assign spi_cs                = spi_cs_q;

endmodule

// File: tb/tb_sd_cmd_generator.sv
// Randomized bench for sd_cmd_generator: an SPI/card model answers each byte, and a
// transaction-level reference predicts the byte stream, CS level and final R1 value.
module tb_sd_cmd_generator;
  localparam int NCR = 8;

  logic        clk, rst;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic        go, ignore_count;
  logic        done, response_ready, data_xfer_in_progress;
  logic [7:0]  response;
  logic        spi_go, spi_done, spi_cs;
  logic [7:0]  spi_tx_data, spi_rx_data;

  sd_cmd_generator #(.NCR_MAX(NCR), .FILL_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .arg(arg), .go(go), .ignore_count(ignore_count),
    .done(done), .response(response), .response_ready(response_ready),
    .data_xfer_in_progress(data_xfer_in_progress), .spi_go(spi_go),
    .spi_tx_data(spi_tx_data), .spi_rx_data(spi_rx_data), .spi_done(spi_done),
    .spi_cs(spi_cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int card_ap = 0;
  logic [7:0] card_av = 8'h00;
  logic [7:0] log_b[$];
  logic       log_cs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC byte by long division of {header, 7 zeros} by the generator 0x89
  function automatic logic [7:0] crc_byte(input logic [5:0] c, input logic [31:0] a);
    logic [46:0] r;
    r = {2'b01, c, a, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return {r[6:0], 1'b1};
  endfunction

  // SPI master + card: random latency, card answers on poll number card_ap (0 = never)
  initial begin
    int k, lat;
    spi_done = 1'b0;
    spi_rx_data = 8'hFF;
    forever begin
      @(negedge clk);
      if (rst && spi_go) begin
        k = log_b.size();
        log_b.push_back(spi_tx_data);
        log_cs.push_back(spi_cs);
        lat = $urandom_range(1, 4);
        repeat (lat) begin
          @(negedge clk);
          chk("spi_go_single", {63'b0, spi_go}, 64'd0);
        end
        spi_rx_data = (k >= 6 && spi_cs == 1'b0 && card_ap != 0 && (k - 5) >= card_ap)
                      ? card_av : 8'hFF;
        spi_done = 1'b1;
        @(negedge clk);
        chk("spi_go_in_done", {63'b0, spi_go}, 64'd0);
        spi_done = 1'b0;
        spi_rx_data = 8'hFF;
      end
    end
  end

  // per-cycle checks: strobes coincide, response only moves with done
  initial begin
    logic [7:0] prev;
    prev = 8'hFF;
    forever begin
      @(negedge clk);
      if (!rst) prev = response;
      else begin
        chk("ready_eq_done", {63'b0, response_ready}, {63'b0, done});
        if (!done) chk("resp_hold", {56'b0, response}, {56'b0, prev});
        if (done) done_cnt++;
        prev = response;
      end
    end
  end

  task automatic run_txn(input logic [5:0] c, input logic [31:0] a, input logic ig,
                         input int ap, input logic [7:0] av, input bit glitch);
    int n, np, exp_n, d0;
    bit busy_bad;
    logic [7:0] exp_resp;
    logic [7:0] exp_b[$];
    card_ap = ap;
    card_av = av;
    log_b.delete();
    log_cs.delete();
    d0 = done_cnt;
    @(negedge clk);
    cmd = c; arg = a; ignore_count = ig; go = 1'b1;
    @(negedge clk);
    go = 1'b0; cmd = 6'($urandom); arg = $urandom; ignore_count = ~ig;
    n = 0; busy_bad = 0;
    while (!done && n < 5000) begin
      if (!data_xfer_in_progress) busy_bad = 1;
      @(negedge clk);
      n++;
      go = (glitch && n == 10);
    end
    go = 1'b0;
    chk("txn_timeout", {63'b0, n >= 5000}, 64'd0);
    if (n >= 5000) return;
    chk("busy_until_done", {63'b0, busy_bad}, 64'd0);
    if (ap != 0 && (ig || ap <= NCR)) begin np = ap; exp_resp = av; end
    else begin np = NCR; exp_resp = 8'hFF; end
    exp_b.push_back({2'b01, c});
    exp_b.push_back(a[31:24]); exp_b.push_back(a[23:16]);
    exp_b.push_back(a[15:8]);  exp_b.push_back(a[7:0]);
    exp_b.push_back(crc_byte(c, a));
    for (int i = 0; i <= np; i++) exp_b.push_back(8'hFF);
    exp_n = exp_b.size();
    chk("response", {56'b0, response}, {56'b0, exp_resp});
    chk("resp_ready", {63'b0, response_ready}, 64'd1);
    chk("busy_low_at_done", {63'b0, data_xfer_in_progress}, 64'd0);
    chk("byte_count", 64'(log_b.size()), 64'(exp_n));
    for (int i = 0; i < exp_n && i < log_b.size(); i++) begin
      chk($sformatf("tx_byte%0d", i), {56'b0, log_b[i]}, {56'b0, exp_b[i]});
      chk($sformatf("cs_byte%0d", i), {63'b0, log_cs[i]}, {63'b0, (i == exp_n - 1)});
    end
    @(negedge clk);
    chk("done_single", {63'b0, done}, 64'd0);
    chk("cs_released", {63'b0, spi_cs}, 64'd1);
    chk("done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int n, d0, ap;
    logic ig;
    rst = 1'b0; go = 1'b0; cmd = '0; arg = '0; ignore_count = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", {63'b0, spi_cs}, 64'd1);
    chk("rst_go", {63'b0, spi_go}, 64'd0);
    chk("rst_resp", {56'b0, response}, 64'hFF);
    chk("rst_tx", {56'b0, spi_tx_data}, 64'hFF);
    chk("rst_done", {62'b0, done, response_ready}, 64'd0);
    chk("rst_busy", {63'b0, data_xfer_in_progress}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    chk("model_crc_cmd0", {56'b0, crc_byte(6'd0, 32'd0)}, 64'h95);
    chk("model_crc_cmd8", {56'b0, crc_byte(6'd8, 32'h1AA)}, 64'h87);

    run_txn(6'd0, 32'd0, 1'b0, 3, 8'h01, 0);
    if (log_b.size() > 5) begin
      chk("t1_b0", {56'b0, log_b[0]}, 64'h40);
      chk("t1_b5", {56'b0, log_b[5]}, 64'h95);
    end
    chk("t1_resp", {56'b0, response}, 64'h01);

    run_txn(6'd8, 32'h1AA, 1'b0, 1, 8'h01, 0);
    if (log_b.size() > 5) begin
      chk("t2_b0", {56'b0, log_b[0]}, 64'h48);
      chk("t2_b4", {56'b0, log_b[4]}, 64'hAA);
      chk("t2_b5", {56'b0, log_b[5]}, 64'h87);
    end

    run_txn(6'h3F, 32'd0, 1'b0, 0, 8'h00, 0);
    chk("t3_polls", 64'(log_b.size()), 64'(6 + NCR + 1));
    chk("t3_resp", {56'b0, response}, 64'hFF);

    run_txn(6'h3F, 32'd0, 1'b1, 20, 8'h00, 0);
    chk("t4_polls", 64'(log_b.size()), 64'(6 + 20 + 1));

    run_txn(6'h11, 32'hDEADBEEF, 1'b0, 2, 8'h05, 1);

    // reset during the argument bytes
    log_b.delete(); log_cs.delete();
    card_ap = 1; card_av = 8'h00;
    @(negedge clk);
    cmd = 6'h12; arg = $urandom; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    d0 = done_cnt;
    n = 0;
    while (log_b.size() < 3 && n < 500) begin @(negedge clk); n++; end
    chk("abort_timeout", {63'b0, n >= 500}, 64'd0);
    rst = 1'b0;
    #1;
    chk("abort_cs", {63'b0, spi_cs}, 64'd1);
    chk("abort_go", {63'b0, spi_go}, 64'd0);
    chk("abort_resp", {56'b0, response}, 64'hFF);
    chk("abort_busy", {63'b0, data_xfer_in_progress}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

    run_txn(6'd17, 32'h0000_0200, 1'b0, 4, 8'h00, 0);

    for (int t = 0; t < 10; t++) begin
      ig = 1'($urandom_range(0, 1));
      ap = ig ? int'($urandom_range(1, 12)) : int'($urandom_range(0, 10));
      run_txn(6'($urandom), $urandom, ig, ap, 8'($urandom_range(0, 127)), bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
